iterative_squarer: RTL and testbench

ITERATIVE_SQUARER -- requirements
Module: iterative_squarer

---
 rtl/iterative_squarer.sv | 115 +++++++++++
 tb/tb_iterative_squarer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_squarer.sv
// Iterative squarer: computes x*x as the sum of the first x odd numbers
// (1 + 3 + ... + (2x-1)) using only adders, one odd term per clock.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start_i   - request to square x_i, accepted only while ready_o is high
//   x_i       - unsigned operand, captured on the accepting edge
//   ready_o   - high only in IDLE
//   done_o    - one-cycle pulse when square_o carries a new result
//   square_o  - registered result, held between completions
module iterative_squarer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   x_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] square_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   counter_q, counter_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // One bit wider than x so the largest odd term 2x-1 (and the final 2x+1) fits.
  logic [WIDTH:0]     odd_q, odd_d;
  logic [2*WIDTH-1:0] square_q, square_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = start_i ? StAccum : StIdle;
      StAccum: state_d = (counter_q == '0) ? StDone : StAccum;
      StDone:  state_d = StIdle;
      // Unreachable encoding recovers to IDLE.
      default: state_d = StIdle;
    endcase
  end

  // Output logic; the unreachable encoding drives both flags low.
  always_comb begin
    ready_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      StIdle:  ready_o = 1'b1;
      StDone:  done_o  = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    counter_d = counter_q;
    acc_d     = acc_q;
    odd_d     = odd_q;
    square_d  = square_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          counter_d = x_i;
          acc_d     = '0;
          odd_d     = {{WIDTH{1'b0}}, 1'b1};
        end
      end
      StAccum: begin
        if (counter_q != '0) begin
          acc_d     = acc_q + {{(WIDTH-1){1'b0}}, odd_q};
          odd_d     = odd_q + {{(WIDTH-1){1'b0}}, 2'd2};
          counter_d = counter_q - 1'b1;
        end else begin
          // Only publish the finished sum; partial sums never reach square_o.
          square_d = acc_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      acc_q     <= '0;
      odd_q     <= {{WIDTH{1'b0}}, 1'b1};
      square_q  <= '0;
    end else begin
      counter_q <= counter_d;
      acc_q     <= acc_d;
      odd_q     <= odd_d;
      square_q  <= square_d;
    end
  end

  assign square_o = square_q;

endmodule

// File: tb/tb_iterative_squarer.sv
// Self-checking bench for iterative_squarer (WIDTH=8 main instance, WIDTH=4 side instance).
// Expected results come from plain arithmetic: square = x*x, done seen x+1 edges after accept.
module tb_iterative_squarer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  x;
  logic        ready;
  logic        done;
  logic [15:0] square;

  logic        start4;
  logic [3:0]  x4;
  logic        ready4;
  logic        done4;
  logic [7:0]  square4;

  int pass_cnt = 0;
  int total_cnt = 0;

  iterative_squarer #(.WIDTH(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .x_i      (x),
    .ready_o  (ready),
    .done_o   (done),
    .square_o (square)
  );

  iterative_squarer #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start4),
    .x_i      (x4),
    .ready_o  (ready4),
    .done_o   (done4),
    .square_o (square4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_square(input int v);
    return v * v;
  endfunction

  // Drives one request from idle (called #1 after an edge) and measures it.
  task automatic do_op(input int xv, output int lat, output logic [15:0] sq,
                       output logic done_next, output logic ready_next);
    start = 1'b1;
    x     = xv[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    x     = $urandom;  // must not influence the running operation
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    sq = square;
    @(posedge clk); #1;
    done_next  = done;
    ready_next = ready;
  endtask

  task automatic check_op(input string name, input int xv);
    int lat;
    logic [15:0] sq;
    logic dn, rd;
    do_op(xv, lat, sq, dn, rd);
    total_cnt++;
    if (lat !== xv + 1) $display("FAIL %s latency: got %0d expected %0d", name, lat, xv + 1);
    else pass_cnt++;
    total_cnt++;
    if (sq !== exp_square(xv)) $display("FAIL %s square: got %0d expected %0d", name, sq,
                                        exp_square(xv));
    else pass_cnt++;
    total_cnt++;
    if (dn !== 1'b0 || rd !== 1'b1)
      $display("FAIL %s after-done: got done=%b ready=%b expected done=0 ready=1", name, dn, rd);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;  x = '0;
    start4 = 1'b0; x4 = '0;
    #2;
    total_cnt++;
    if (ready !== 1'b1 || done !== 1'b0 || square !== 16'd0)
      $display("FAIL reset: got ready=%b done=%b square=%0d expected 1 0 0", ready, done, square);
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    check_op("x5", 5);
    check_op("x0", 0);
    check_op("x1", 1);
  endtask

  task automatic test_max;
    int lat;
    check_op("x255", 255);
    start4 = 1'b1;
    x4 = 4'd15;
    @(posedge clk); #1;
    start4 = 1'b0;
    x4 = 4'd3;
    lat = 0;
    while (!done4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat !== 16 || square4 !== 8'd225)
      $display("FAIL w4_x15: got lat=%0d square=%0d expected lat=16 square=225", lat, square4);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore;
    int dones = 0;
    int lat = -1;
    start = 1'b1;
    x = 8'd3;
    @(posedge clk); #1;      // accepted
    x = 8'd9;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;            // toggled while busy
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (lat < 0) lat = i;
        total_cnt++;
        if (square !== 16'd9) $display("FAIL ignore square: got %0d expected 9", square);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (dones !== 1 || lat !== 4)
      $display("FAIL ignore done: got count=%0d at=%0d expected count=1 at=4", dones, lat);
    else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL ignore idle: got ready=%b expected 1", ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    int ready_between = 0;
    logic [15:0] sq1 = '0;
    logic [15:0] sq2 = '0;
    start = 1'b1;
    x = 8'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (dones == 1) begin
          sq1 = square;
          x = 8'd3;
        end else if (dones == 2) begin
          sq2 = square;
          start = 1'b0;
        end
      end else if (dones == 1 && ready) begin
        ready_between++;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (dones !== 2) $display("FAIL b2b count: got %0d expected 2", dones);
    else pass_cnt++;
    total_cnt++;
    if (sq1 !== 16'd4 || sq2 !== 16'd9)
      $display("FAIL b2b squares: got %0d,%0d expected 4,9", sq1, sq2);
    else pass_cnt++;
    total_cnt++;
    if (ready_between !== 1) $display("FAIL b2b gap: got %0d ready cycles expected 1",
                                      ready_between);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    start = 1'b1;
    x = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;  // no clock edge in between
    total_cnt++;
    if (square !== 16'd0 || ready !== 1'b1 || done !== 1'b0)
      $display("FAIL abort async: got square=%0d ready=%b done=%b expected 0 1 0",
               square, ready, done);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total_cnt++;
    if (dones !== 0 || square !== 16'd0)
      $display("FAIL abort quiet: got dones=%0d square=%0d expected 0 0", dones, square);
    else pass_cnt++;
    // Release, then request straight away on the first edge.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    check_op("after_reset_x7", 7);
  endtask

  task automatic test_random;
    for (int n = 0; n < 15; n++) begin
      int v;
      v = (n < 3) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      check_op("random", v);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
